// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the board counter sequencer: state encoding,
// count width and the default prescaler terminal value.
package counter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_RUN   = RUN,
    ST_PAUSE = PAUSE,
    ST_DONE  = DONE
  } seq_state_t;

  localparam int COUNT_W       = 4;
  localparam int DIV_WIDTH_DEF = 27;
  localparam int DIV_MAX_DEF   = 2**27 - 1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command and status bundle between the board controls and the sequencer.
// master drives commands and watches status; slave is the sequencer side.
interface counter_sequencer_if;
  import counter_pkg::*;

  logic               clr;
  logic               start;
  logic               stop;
  logic               load;
  logic [COUNT_W-1:0] load_val;
  logic               up_dn;
  logic               one_shot;
  logic [COUNT_W-1:0] count;
  logic               tick;
  logic               running;
  logic               done;

  modport master (
    output clr, start, stop, load, load_val, up_dn, one_shot,
    input  count, tick, running, done
  );

  modport slave (
    input  clr, start, stop, load, load_val, up_dn, one_shot,
    output count, tick, running, done
  );

endinterface

// File: rtl/counter_sequencer_tick_prescaler.sv
// Free-running prescaler: counts enabled cycles 0..DIV_MAX and flags the
// terminal cycle combinationally on wrap. sync_clr overrides en.
module tick_prescaler #(
  parameter int DIV_WIDTH = 27,
  parameter int DIV_MAX   = 2**27 - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic wrap
);

  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] cnt;

  assign wrap = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer for the 4-bit board counter: prescaled up/down count
// with wrap or one-shot stop, driven by clr/load/stop/start commands.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_MAX   = DIV_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_sequencer_if.slave bus
);

  seq_state_t         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick_q, tick_d;
  logic               running_q, done_q;
  logic               presc_en, presc_clr, presc_wrap;
  logic               go;
  logic [COUNT_W-1:0] count_step;
  logic               at_terminal;

  tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (presc_en),
    .sync_clr (presc_clr),
    .wrap     (presc_wrap)
  );

  // stop always beats start when both are high
  assign go          = bus.start && !bus.stop;
  assign count_step  = bus.up_dn ? count_q + 1'b1 : count_q - 1'b1;
  assign at_terminal = bus.up_dn ? (count_step == '1) : (count_step == '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;

    if (bus.clr) begin
      count_d   = '0;
      presc_clr = 1'b1;
      state_d   = ST_IDLE;
    end else if (bus.load) begin
      // load owns count and prescaler; start/stop still steer the state
      count_d   = bus.load_val;
      presc_clr = 1'b1;
      unique case (state_q)
        ST_RUN:   if (bus.stop) state_d = ST_PAUSE;
        ST_DONE:  state_d = go ? ST_RUN : ST_IDLE;
        default:  if (go) state_d = ST_RUN;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            presc_clr = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else begin
            presc_en = 1'b1;
            if (presc_wrap) begin
              count_d = count_step;
              tick_d  = 1'b1;
              if (bus.one_shot && at_terminal) state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (go) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (go) begin
            count_d   = bus.up_dn ? '0 : '1;
            presc_clr = 1'b1;
            state_d   = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DIV_MAX=3 (one step per 4 run cycles).
module tb_counter_sequencer;
  import counter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   tick_seen;

  counter_sequencer_if bus ();

  counter_sequencer #(
    .DIV_WIDTH (4),
    .DIV_MAX   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmds_off();
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.load  = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.load_val  = 4'h0;
    bus.up_dn     = 1'b1;
    bus.one_shot  = 1'b0;
    cmds_off();

    // reset state
    #12;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_running", 32'(bus.running), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;

    // wrap up: steps every 4 edges, F->0 wrap
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("start_running", 32'(bus.running), 32'h1);
    check("start_count", 32'(bus.count), 32'h0);
    for (int i = 1; i <= 17; i++) begin
      cyc(3);
      check("wrap_pre", 32'(bus.count), 32'((i - 1) % 16));
      check("wrap_pre_tick", 32'(bus.tick), 32'h0);
      cyc(1);
      check("wrap_step", 32'(bus.count), 32'(i % 16));
      check("wrap_tick", 32'(bus.tick), 32'h1);
    end
    cyc(1);
    check("tick_fall", 32'(bus.tick), 32'h0);

    // pause/resume: prescaler holds at 2, so the step lands 2 edges after resume
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("pause_running", 32'(bus.running), 32'h0);
    check("pause_count", 32'(bus.count), 32'h1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    cmds_off();
    check("pause_startstop", 32'(bus.running), 32'h0);
    cyc(9);
    check("pause_hold_count", 32'(bus.count), 32'h1);
    check("pause_hold_tick", 32'(bus.tick), 32'h0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("resume_running", 32'(bus.running), 32'h1);
    cyc(1);
    check("resume_pre", 32'(bus.count), 32'h1);
    cyc(1);
    check("resume_step", 32'(bus.count), 32'h2);
    check("resume_tick", 32'(bus.tick), 32'h1);

    // one-shot down from 3
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    check("clr_count", 32'(bus.count), 32'h0);
    check("clr_running", 32'(bus.running), 32'h0);
    bus.load_val = 4'h3;
    bus.load     = 1'b1;
    bus.up_dn    = 1'b0;
    bus.one_shot = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    check("load_count", 32'(bus.count), 32'h3);
    check("load_idle", 32'(bus.running), 32'h0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc(3);
      check("down_pre", 32'(bus.count), 32'(4 - i));
      cyc(1);
      check("down_step", 32'(bus.count), 32'(3 - i));
    end
    check("os_done", 32'(bus.done), 32'h1);
    check("os_running", 32'(bus.running), 32'h0);
    check("os_tick", 32'(bus.tick), 32'h1);
    tick_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (bus.tick) tick_seen++;
    end
    check("done_no_ticks", 32'(tick_seen), 32'h0);
    check("done_hold", 32'(bus.count), 32'h0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("restart_count", 32'(bus.count), 32'hF);
    check("restart_running", 32'(bus.running), 32'h1);
    check("restart_done", 32'(bus.done), 32'h0);

    // priority: clr beats load and start; load with start runs from load_val
    bus.clr      = 1'b1;
    bus.load     = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = 4'h5;
    cyc(1);
    bus.clr = 1'b0;
    check("prio_clr_count", 32'(bus.count), 32'h0);
    check("prio_clr_running", 32'(bus.running), 32'h0);
    cyc(1);
    cmds_off();
    check("prio_load_count", 32'(bus.count), 32'h5);
    check("prio_load_running", 32'(bus.running), 32'h1);
    bus.up_dn    = 1'b1;
    bus.one_shot = 1'b0;
    cyc(3);
    check("prio_pre", 32'(bus.count), 32'h5);
    cyc(1);
    check("prio_step", 32'(bus.count), 32'h6);

    // async reset between edges
    cyc(2);
    check("pre_arst_running", 32'(bus.running), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_running", 32'(bus.running), 32'h0);
    check("arst_tick", 32'(bus.tick), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    #3;
    rst_n = 1'b1;
    cyc(8);
    check("post_arst_count", 32'(bus.count), 32'h0);
    check("post_arst_idle", 32'(bus.running), 32'h0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    cmds_off();
    check("idle_startstop", 32'(bus.running), 32'h0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("post_arst_start", 32'(bus.running), 32'h1);
    cyc(3);
    check("post_arst_pre", 32'(bus.count), 32'h0);
    cyc(1);
    check("post_arst_step", 32'(bus.count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run-control sequencer for the 4-bit board counter. It derives a slow count tick from the 100 MHz board clock with a programmable prescaler and steps the count up or down, in wrap or one-shot mode. It sequences the count through idle, run, pause and done under start/stop/clear/load commands from the board pushbuttons and switches, and it drives the LED count directly.

## Interface
- DIV_WIDTH, 27: prescaler width in bits.
- DIV_MAX, 2**27-1: prescaler terminal value; one count step every DIV_MAX+1 run cycles (~0.75 Hz at 100 MHz).

- clk  in  1  board clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear command (level, sampled every edge).
- start  in  1  start/resume command (level).
- stop  in  1  pause command (level).
- load  in  1  synchronous load of load_val.
- load_val  in  4  value loaded into count.
- up_dn  in  1  1 = count up, 0 = count down.
- one_shot  in  1  1 = stop at terminal value, 0 = wrap.
- count  out  4  current count, registered.
- tick  out  1  one-cycle pulse, high in the cycle after each count step.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Command priority per edge: clr > load > stop > start > prescaler tick.
- clr, in any state: count=0, prescaler=0, next state IDLE.
- load: count=load_val, prescaler=0. State is unchanged, except DONE goes to IDLE.
- IDLE: start goes to RUN with prescaler=0.
- RUN: stop goes to PAUSE. When stop is low, the prescaler increments each cycle. At prescaler==DIV_MAX the prescaler goes to 0 and count steps ±1 per up_dn sampled on that edge.
- One-shot terminal: with one_shot=1, a step that lands on 4'hF (up) or 4'h0 (down) moves the block to DONE on the same edge.
- Wrap mode: with one_shot=0, counting wraps F→0 (up) and 0→F (down).
- PAUSE: prescaler and count hold. start returns to RUN and the prescaler resumes from its held value.
- DONE: count holds. start reloads count to 0 (up_dn=1) or F (up_dn=0), sets prescaler=0 and goes to RUN.
- start and stop high together: stop wins. From IDLE or DONE, nothing happens.
- Mode inputs: up_dn and one_shot changes take effect at the next step edge only.
- No step occurs on any edge where clr, load or stop is asserted.

## Timing
- Reset values: count=0, tick=0, running=0, done=0, state=IDLE, prescaler=0.
- rst_n low clears everything immediately, regardless of clk, including mid-run.
- First step after start: start sampled at edge E in IDLE gives the first count change at edge E+DIV_MAX+1, then every DIV_MAX+1 edges while in RUN.
- tick rises on the same edge count changes and falls on the next edge.
- running and done are registered state decodes and change on the transition edge.
- count, load and clr: 1-edge latency.

## Structure
- Shared package counter_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - COUNT_W=4;
  - the default DIV_MAX.
- Sub-module tick_prescaler(DIV_WIDTH, DIV_MAX) has inputs clk, rst_n, en and sync_clr, and output wrap.
  - wrap is combinational and high when en && cnt==DIV_MAX.
  - The prescaler counter is the only thing inside it.
- The FSM, count register and output registers live in counter_sequencer.

## Test plan
All scenarios use DIV_MAX=3.
- Wrap up: reset, start pulse, up_dn=1, one_shot=0 → count 1,2,3… every 4 edges, F→0 wrap, tick high 1 cycle per step.
- Pause/resume: stop 2 edges after a step, hold 10 cycles, start → count frozen, next step 2 edges after resume.
- One-shot down: load_val=3, load, up_dn=0, one_shot=1, start → count 2,1,0, done=1, running=0, further ticks none. Then start → count=F, RUN.
- Priority: clr, load and start high on one edge → count=0, IDLE. load and start together → count=load_val, state per start. start and stop together in PAUSE → stays PAUSE.
- Async reset mid-RUN: assert rst_n low between edges → all outputs 0 immediately. After release, start required before any step.
